// File: rtl/op2_shifter_if.sv
// Request/result bundle for the ARM operand-2 shifter: valid/ready request
// fields in, registered operand and carry-out back with their own valid/ready.
interface op2_shifter_if;
  logic        in_valid;
  logic        in_ready;
  logic        imm_op;
  logic [7:0]  imm8;
  logic [3:0]  rot;
  logic [31:0] rm_val;
  logic [1:0]  shift_type;
  logic        shift_reg;
  logic [4:0]  shift_imm;
  logic [31:0] rs_val;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op2;
  logic        shc;

  modport slave (
    input  in_valid, imm_op, imm8, rot, rm_val, shift_type, shift_reg,
           shift_imm, rs_val, c_in, out_ready,
    output in_ready, out_valid, op2, shc
  );

  modport master (
    output in_valid, imm_op, imm8, rot, rm_val, shift_type, shift_reg,
           shift_imm, rs_val, c_in, out_ready,
    input  in_ready, out_valid, op2, shc
  );
endinterface

// File: rtl/op2_shifter.sv
// ARM data-processing operand-2 generator (barrel shifter + carry-out), registered.
// Define OP2_SHIFTER_FASTREG_EN to complete register shifts in one cycle instead of two.
module op2_shifter (
  input  logic         clk,
  input  logic         rst_n,
  op2_shifter_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

`ifdef OP2_SHIFTER_FASTREG_EN
  localparam logic FASTREG = 1'b1;
`else
  localparam logic FASTREG = 1'b0;
`endif

  // Rotated immediate; returns {carry, value}.
  function automatic logic [32:0] rot_imm(input logic [7:0] imm8,
                                          input logic [3:0] rot,
                                          input logic       c_in);
    logic [4:0]  r;
    logic [63:0] d;
    logic [31:0] v;
    logic        c;
    r = {rot, 1'b0};
    d = {24'd0, imm8, 24'd0, imm8} >> r;
    v = d[31:0];
    c = (rot == 4'd0) ? c_in : v[31];
    return {c, v};
  endfunction

  // Shifted Rm; returns {carry, value}. Immediate amount 0 carries the
  // special encodings LSR#32, ASR#32 and RRX.
  function automatic logic [32:0] shift_op(input logic [31:0] rm,
                                           input logic [1:0]  st,
                                           input logic        is_reg,
                                           input logic [7:0]  amt,
                                           input logic        c_in);
    logic [7:0]         a;
    logic [4:0]         r;
    logic [32:0]        t;
    logic signed [32:0] ts;
    logic [63:0]        d;
    logic [31:0]        v;
    logic               c;
    a  = amt;
    r  = amt[4:0];
    t  = '0;
    ts = '0;
    d  = '0;
    v  = rm;
    c  = c_in;
    if (!is_reg && (amt == 8'd0) && ((st == SH_LSR) || (st == SH_ASR)))
      a = 8'd32;
    if (!is_reg && (amt == 8'd0) && (st == SH_ROR)) begin
      v = {c_in, rm[31:1]};
      c = rm[0];
    end else if (a != 8'd0) begin
      case (st)
        SH_LSL: begin
          if (a <= 8'd32) begin
            t = {1'b0, rm} << a;
            v = t[31:0];
            c = t[32];
          end else begin
            v = '0;
            c = 1'b0;
          end
        end
        SH_LSR: begin
          if (a <= 8'd32) begin
            t = {rm, 1'b0} >> a;
            v = t[32:1];
            c = t[0];
          end else begin
            v = '0;
            c = 1'b0;
          end
        end
        SH_ASR: begin
          // A guard bit below Rm catches the last bit shifted out.
          ts = {rm, 1'b0};
          ts = ts >>> ((a >= 8'd32) ? 8'd32 : a);
          v  = ts[32:1];
          c  = ts[0];
        end
        default: begin
          if (r == 5'd0) begin
            v = rm;
            c = rm[31];
          end else begin
            d = {rm, rm} >> r;
            v = d[31:0];
            c = d[31];
          end
        end
      endcase
    end
    return {c, v};
  endfunction

  logic [0:0]  state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] op2_q, op2_d;
  logic        shc_q, shc_d;
  logic [31:0] req_rm_q, req_rm_d;
  logic [1:0]  req_type_q, req_type_d;
  logic [7:0]  req_amt_q, req_amt_d;
  logic        req_cin_q, req_cin_d;

  logic        in_ready_c;
  logic        accept;
  logic        in_exec;
  logic [31:0] src_rm;
  logic [1:0]  src_type;
  logic        src_reg;
  logic [7:0]  src_amt;
  logic        src_cin;
  logic [32:0] res;
  logic        unused_rs_hi;

  assign unused_rs_hi = ^bus.rs_val[31:8];

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    op2_d       = op2_q;
    shc_d       = shc_q;
    req_rm_d    = req_rm_q;
    req_type_d  = req_type_q;
    req_amt_d   = req_amt_q;
    req_cin_d   = req_cin_q;

    in_exec    = (state_q == S_EXEC);
    in_ready_c = !in_exec && (!out_valid_q || bus.out_ready);
    accept     = bus.in_valid && in_ready_c;

    // One shifter serves both the live request and the one parked for EXEC.
    src_rm   = in_exec ? req_rm_q   : bus.rm_val;
    src_type = in_exec ? req_type_q : bus.shift_type;
    src_reg  = in_exec ? 1'b1       : bus.shift_reg;
    src_amt  = in_exec ? req_amt_q  :
               (bus.shift_reg ? bus.rs_val[7:0] : {3'b000, bus.shift_imm});
    src_cin  = in_exec ? req_cin_q  : bus.c_in;

    if (!in_exec && bus.imm_op)
      res = rot_imm(bus.imm8, bus.rot, bus.c_in);
    else
      res = shift_op(src_rm, src_type, src_reg, src_amt, src_cin);

    if (out_valid_q && bus.out_ready)
      out_valid_d = 1'b0;

    if (in_exec) begin
      op2_d       = res[31:0];
      shc_d       = res[32];
      out_valid_d = 1'b1;
      state_d     = S_IDLE;
    end else if (accept) begin
      if (!bus.imm_op && bus.shift_reg && !FASTREG) begin
        req_rm_d   = bus.rm_val;
        req_type_d = bus.shift_type;
        req_amt_d  = bus.rs_val[7:0];
        req_cin_d  = bus.c_in;
        state_d    = S_EXEC;
      end else begin
        op2_d       = res[31:0];
        shc_d       = res[32];
        out_valid_d = 1'b1;
      end
    end
  end

  // Control and visible output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      op2_q       <= 32'h0;
      shc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      op2_q       <= op2_d;
      shc_q       <= shc_d;
    end
  end

  // Parked register-shift request; only read while in EXEC
  always_ff @(posedge clk) begin
    req_rm_q   <= req_rm_d;
    req_type_q <= req_type_d;
    req_amt_q  <= req_amt_d;
    req_cin_q  <= req_cin_d;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.op2       = op2_q;
  assign bus.shc       = shc_q;

endmodule

// File: tb/tb_op2_shifter.sv
// Scoreboard bench for op2_shifter: a bit-serial reference model predicts each
// result at acceptance; the output monitor pops and compares on every transfer.
module tb_op2_shifter;

  logic clk;
  logic rst_n;
  op2_shifter_if bus();

  op2_shifter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_wait = 0;
  logic [32:0] exp_q[$];
  int          pop_cyc[$];
  logic [32:0] mon_e;
  logic [32:0] discard;
  logic        rand_rdy = 1'b0;

`ifdef OP2_SHIFTER_FASTREG_EN
  localparam logic FAST = 1'b1;
`else
  localparam logic FAST = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: ARM semantics applied one bit position at a time.
  function automatic logic [32:0] ref_model(input logic imm_op, input logic [7:0] imm8,
                                            input logic [3:0] rot, input logic [31:0] rm,
                                            input logic [1:0] st, input logic sreg,
                                            input logic [4:0] simm, input logic [31:0] rs,
                                            input logic cin);
    logic [31:0] v;
    logic        c;
    int          a;
    c = cin;
    if (imm_op) begin
      v = {24'd0, imm8};
      for (int i = 0; i < 2 * int'(rot); i++) v = {v[0], v[31:1]};
      if (rot != 4'd0) c = v[31];
      return {c, v};
    end
    v = rm;
    if (sreg) a = int'(rs[7:0]);
    else begin
      a = int'(simm);
      if (a == 0) begin
        if (st == 2'b11) return {rm[0], cin, rm[31:1]};
        if (st != 2'b00) a = 32;
      end
    end
    for (int i = 0; i < a; i++) begin
      case (st)
        2'b00: begin c = v[31]; v = v << 1; end
        2'b01: begin c = v[0];  v = v >> 1; end
        2'b10: begin c = v[0];  v = {v[31], v[31:1]}; end
        default: begin c = v[0]; v = {v[0], v[31:1]}; end
      endcase
    end
    return {c, v};
  endfunction

  task automatic send(input logic imm_op, input logic [7:0] imm8, input logic [3:0] rot,
                      input logic [31:0] rm, input logic [1:0] st, input logic sreg,
                      input logic [4:0] simm, input logic [31:0] rs, input logic cin);
    int w;
    bus.imm_op = imm_op;  bus.imm8 = imm8;       bus.rot = rot;
    bus.rm_val = rm;      bus.shift_type = st;   bus.shift_reg = sreg;
    bus.shift_imm = simm; bus.rs_val = rs;       bus.c_in = cin;
    bus.in_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.in_ready && w < 50);
    if (bus.in_ready)
      exp_q.push_back(ref_model(imm_op, imm8, rot, rm, st, sreg, simm, rs, cin));
    else
      check_eq("accept_timeout", 64'd0, 64'd1);
    last_wait = w;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: a transfer seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_output", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("op2", 64'(bus.op2), 64'(mon_e[31:0]));
        check_eq("shc", 64'(bus.shc), 64'(mon_e[32]));
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [32:0] e;
    logic [7:0]  amts [5];
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.imm_op = 1'b0; bus.imm8 = '0; bus.rot = '0;
    bus.rm_val = '0; bus.shift_type = '0; bus.shift_reg = 1'b0; bus.shift_imm = '0;
    bus.rs_val = '0; bus.c_in = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_op2", 64'(bus.op2), 64'd0);
    check_eq("rst_shc", 64'(bus.shc), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Rotated immediates
    send(1'b1, 8'hFF, 4'd4, 32'h0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0);
    check_eq("imm_latency", 64'(bus.out_valid), 64'd1);
    send(1'b1, 8'hFF, 4'd0, 32'h0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b1);
    send(1'b1, 8'h3C, 4'd1, 32'h0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b1);

    // Immediate-shift encodings with amount 0 and normal amounts
    send(1'b0, 8'h0, 4'd0, 32'h80000001, 2'b01, 1'b0, 5'd0, 32'h0, 1'b0);
    send(1'b0, 8'h0, 4'd0, 32'h80000001, 2'b10, 1'b0, 5'd0, 32'h0, 1'b0);
    send(1'b0, 8'h0, 4'd0, 32'h80000001, 2'b11, 1'b0, 5'd0, 32'h0, 1'b0);
    send(1'b0, 8'h0, 4'd0, 32'h80000001, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0);
    send(1'b0, 8'h0, 4'd0, 32'hC0000003, 2'b00, 1'b0, 5'd1, 32'h0, 1'b0);
    send(1'b0, 8'h0, 4'd0, 32'h90000006, 2'b10, 1'b0, 5'd2, 32'h0, 1'b0);
    send(1'b0, 8'h0, 4'd0, 32'h0000000F, 2'b11, 1'b0, 5'd31, 32'h0, 1'b0);
    drain();

    // Register shifts; latency checked on the first
    send(1'b0, 8'h0, 4'd0, 32'h80000001, 2'b00, 1'b1, 5'd0, 32'd32, 1'b0);
    check_eq("reg_latency_n", 64'(bus.out_valid), FAST ? 64'd1 : 64'd0);
    @(posedge clk);
    #1;
    if (!FAST) check_eq("reg_latency_n1", 64'(bus.out_valid), 64'd1);
    send(1'b0, 8'h0, 4'd0, 32'h80000001, 2'b00, 1'b1, 5'd0, 32'd33, 1'b0);
    send(1'b0, 8'h0, 4'd0, 32'h80000001, 2'b11, 1'b1, 5'd0, 32'd32, 1'b0);
    send(1'b0, 8'h0, 4'd0, 32'h80000001, 2'b11, 1'b1, 5'd0, 32'd36, 1'b0);
    send(1'b0, 8'h0, 4'd0, 32'h80000001, 2'b01, 1'b1, 5'd0, 32'h00000100, 1'b1);
    send(1'b0, 8'h0, 4'd0, 32'h80000001, 2'b01, 1'b1, 5'd0, 32'd32, 1'b0);
    send(1'b0, 8'h0, 4'd0, 32'h80000001, 2'b10, 1'b1, 5'd0, 32'd200, 1'b0);
    drain();

    // Backpressure: result held for 3 cycles, then take and accept together
    bus.out_ready = 1'b0;
    send(1'b1, 8'hA5, 4'd2, 32'h0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0);
    e = ref_model(1'b1, 8'hA5, 4'd2, 32'h0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0);
    bus.in_valid = 1'b1;
    bus.imm8 = 8'h11;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check_eq("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check_eq("bp_op2_hold", 64'(bus.op2), 64'(e[31:0]));
      check_eq("bp_shc_hold", 64'(bus.shc), 64'(e[32]));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(1'b1, 8'h81, 4'd15, 32'h0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0);
    check_eq("bp_same_cycle_accept", 64'(last_wait), 64'd1);
    check_eq("bp_out_valid_stays", 64'(bus.out_valid), 64'd1);
    drain();

    // Four back-to-back immediates
    pop_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'(8'h10 + i), 4'(i), 32'h0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0);
      check_eq("pipe_accept_wait", 64'(last_wait), 64'd1);
    end
    drain();
    check_eq("pipe_count", 64'(pop_cyc.size()), 64'd4);
    if (pop_cyc.size() == 4)
      for (int i = 1; i < 4; i++)
        check_eq("pipe_consecutive", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);

    // Reset while a register shift is in flight
    send(1'b0, 8'h0, 4'd0, 32'h12345678, 2'b00, 1'b1, 5'd0, 32'd4, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("midrst_op2", 64'(bus.op2), 64'd0);
    discard = exp_q.pop_back();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("midrst_no_output", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Random traffic with random backpressure
    amts[0] = 8'd0; amts[1] = 8'd31; amts[2] = 8'd32; amts[3] = 8'd33; amts[4] = 8'd1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      logic [31:0] rs;
      rs = $urandom;
      if ($urandom_range(0, 1) == 1) rs[7:0] = amts[$urandom_range(0, 4)];
      send(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom), $urandom,
           2'($urandom), 1'($urandom_range(0, 1)), 5'($urandom), rs, 1'($urandom_range(0, 1)));
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
